// File: rtl/dds_hop_pkg.sv
// Shared state and mode encodings for the DDS frequency-hop scheduler.
package dds_hop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DWELL,
    ST_ERR
  } hop_state_t;

  localparam logic [1:0] MODE_FIXED  = 2'd0;
  localparam logic [1:0] MODE_WRAP   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;

  localparam int KHZ_W  = 24;
  localparam int STEP_W = 16;
  localparam int IDX_W  = 16;

endpackage

// File: rtl/dds_prt_gen.sv
// Pulse-repetition gate: free-running period counter with a high-width comparator.
// Only present when DDS_HOP_PRT_EN is defined.
`ifdef DDS_HOP_PRT_EN
module dds_prt_gen #(
  parameter int DWELL_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [DWELL_W-1:0] prt_cycle,
  input  logic [DWELL_W-1:0] prt_width,
  output logic               prt
);

  localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt >= prt_cycle - ONE) ? '0 : cnt + ONE;
    end
  end

  // A zero period disables the gate; a width covering the whole period holds it high.
  assign prt = en && (prt_cycle != '0) && ((prt_width >= prt_cycle) || (cnt < prt_width));

endmodule
`endif

// File: rtl/dds_hop_sched.sv
// DDS frequency-hop scheduler: fixed, ramp-wrap and ramp-bounce tuning-word sequencer.
// Define DDS_HOP_PRT_EN to compile in the pulse-repetition gate generator.
module dds_hop_sched
  import dds_hop_pkg::*;
#(
  parameter logic [31:0] FTW_PER_KHZ = 32'd4295,
  parameter int          DWELL_W     = 32
) (
  input  logic               clk_user_bufg,
  input  logic               rst_glb,
  input  logic               run_en,
  input  logic [1:0]         cfg_mode,
  input  logic [KHZ_W-1:0]   cfg_fix_khz,
  input  logic [KHZ_W-1:0]   cfg_start_khz,
  input  logic [KHZ_W-1:0]   cfg_stop_khz,
  input  logic [STEP_W-1:0]  cfg_step_khz,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [DWELL_W-1:0] cfg_prt_cycle,
  input  logic [DWELL_W-1:0] cfg_prt_width,
  output logic [31:0]        ftw_o,
  output logic               ftw_upd_o,
  output logic               prt_o,
  output logic [IDX_W-1:0]   hop_idx_o,
  output logic               busy_o,
  output logic               cfg_err_o
);

  localparam logic [DWELL_W-1:0] DW_ONE = DWELL_W'(1);

  hop_state_t         state;
  logic               armed;
  logic               dir_dn;
  logic               fixed_done;
  logic [1:0]         mode_q;
  logic [KHZ_W-1:0]   fix_q, start_q, stop_q, cur_khz;
  logic [STEP_W-1:0]  step_q;
  logic [IDX_W-1:0]   cur_idx;
  logic [DWELL_W-1:0] dwell_q, dwell_cnt;

  logic               is_ramp_in, is_ramp_q, cfg_bad;
  logic [KHZ_W:0]     sum_up, lo_lim;
  logic [KHZ_W-1:0]   nxt_khz;
  logic [IDX_W-1:0]   nxt_idx;
  logic               nxt_dn;

  function automatic logic [31:0] khz_to_ftw(input logic [KHZ_W-1:0] khz);
    return 32'(khz) * FTW_PER_KHZ;
  endfunction

  assign is_ramp_in = (cfg_mode == MODE_WRAP) || (cfg_mode == MODE_BOUNCE);
  assign is_ramp_q  = (mode_q == MODE_WRAP) || (mode_q == MODE_BOUNCE);
  assign cfg_bad    = is_ramp_in && ((cfg_start_khz > cfg_stop_khz) || (cfg_step_khz == '0));

  // Next hop; the extra sum bit keeps cur+step and start+step from wrapping.
  always_comb begin
    sum_up  = {1'b0, cur_khz} + (KHZ_W+1)'(step_q);
    lo_lim  = {1'b0, start_q} + (KHZ_W+1)'(step_q);
    nxt_khz = cur_khz;
    nxt_idx = cur_idx + 16'd1;
    nxt_dn  = dir_dn;
    if (mode_q == MODE_WRAP) begin
      if (sum_up > {1'b0, stop_q}) begin
        nxt_khz = start_q;
        nxt_idx = '0;
      end else begin
        nxt_khz = sum_up[KHZ_W-1:0];
      end
    end else if (!dir_dn) begin
      if (sum_up > {1'b0, stop_q}) begin
        nxt_dn  = 1'b1;
        nxt_khz = ({1'b0, cur_khz} < lo_lim) ? start_q : cur_khz - KHZ_W'(step_q);
      end else begin
        nxt_khz = sum_up[KHZ_W-1:0];
      end
    end else begin
      if ({1'b0, cur_khz} < lo_lim) begin
        nxt_dn  = 1'b0;
        nxt_khz = (sum_up > {1'b0, stop_q}) ? stop_q : sum_up[KHZ_W-1:0];
      end else begin
        nxt_khz = cur_khz - KHZ_W'(step_q);
      end
    end
  end

  always_ff @(posedge clk_user_bufg or negedge rst_glb) begin
    if (!rst_glb) begin
      state      <= ST_IDLE;
      armed      <= 1'b0;
      dir_dn     <= 1'b0;
      fixed_done <= 1'b0;
      mode_q     <= '0;
      fix_q      <= '0;
      start_q    <= '0;
      stop_q     <= '0;
      step_q     <= '0;
      dwell_q    <= '0;
      dwell_cnt  <= '0;
      cur_khz    <= '0;
      cur_idx    <= '0;
      ftw_o      <= '0;
      ftw_upd_o  <= 1'b0;
      hop_idx_o  <= '0;
      busy_o     <= 1'b0;
      cfg_err_o  <= 1'b0;
    end else begin
      ftw_upd_o <= 1'b0;
      // A run only starts after run_en has been seen low at least once.
      if (!run_en) armed <= 1'b1;
      if (state != ST_IDLE && !run_en) begin
        state     <= ST_IDLE;
        busy_o    <= 1'b0;
        cfg_err_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (run_en && armed) begin
              state  <= ST_LOAD;
              busy_o <= 1'b1;
              armed  <= 1'b0;
            end
          end
          ST_LOAD: begin
            mode_q     <= cfg_mode;
            fix_q      <= cfg_fix_khz;
            start_q    <= cfg_start_khz;
            stop_q     <= cfg_stop_khz;
            step_q     <= cfg_step_khz;
            dwell_q    <= cfg_dwell;
            cur_khz    <= is_ramp_in ? cfg_start_khz : cfg_fix_khz;
            cur_idx    <= '0;
            dir_dn     <= 1'b0;
            dwell_cnt  <= '0;
            fixed_done <= 1'b0;
            if (cfg_bad) begin
              state     <= ST_ERR;
              busy_o    <= 1'b0;
              cfg_err_o <= 1'b1;
            end else begin
              state <= ST_DWELL;
            end
          end
          ST_DWELL: begin
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - DW_ONE;
            end else if (!fixed_done) begin
              ftw_o     <= khz_to_ftw(cur_khz);
              ftw_upd_o <= 1'b1;
              hop_idx_o <= cur_idx;
              dwell_cnt <= (dwell_q == '0) ? '0 : dwell_q - DW_ONE;
              if (is_ramp_q) begin
                cur_khz <= nxt_khz;
                cur_idx <= nxt_idx;
                dir_dn  <= nxt_dn;
              end else begin
                fixed_done <= 1'b1;
              end
            end
          end
          ST_ERR:  ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef DDS_HOP_PRT_EN
  logic [DWELL_W-1:0] prt_cycle_q, prt_width_q;

  always_ff @(posedge clk_user_bufg or negedge rst_glb) begin
    if (!rst_glb) begin
      prt_cycle_q <= '0;
      prt_width_q <= '0;
    end else if (state == ST_LOAD) begin
      prt_cycle_q <= cfg_prt_cycle;
      prt_width_q <= cfg_prt_width;
    end
  end

  dds_prt_gen #(.DWELL_W(DWELL_W)) u_prt_gen (
    .clk       (clk_user_bufg),
    .rst_n     (rst_glb),
    .clr       (state == ST_LOAD),
    .en        (state == ST_DWELL),
    .prt_cycle (prt_cycle_q),
    .prt_width (prt_width_q),
    .prt       (prt_o)
  );
`else
  logic unused_prt_cfg;
  assign unused_prt_cfg = ^{cfg_prt_cycle, cfg_prt_width};
  assign prt_o          = 1'b0;
`endif

endmodule

// File: tb/tb_dds_hop_sched.sv
// Scoreboard bench for dds_hop_sched: strobes are matched against queued kHz/index/cycle entries.
module tb_dds_hop_sched;

  logic        clk_user_bufg = 1'b0;
  logic        rst_glb;
  logic        run_en;
  logic [1:0]  cfg_mode;
  logic [23:0] cfg_fix_khz, cfg_start_khz, cfg_stop_khz;
  logic [15:0] cfg_step_khz;
  logic [31:0] cfg_dwell, cfg_prt_cycle, cfg_prt_width;
  logic [31:0] ftw_o;
  logic        ftw_upd_o, prt_o, busy_o, cfg_err_o;
  logic [15:0] hop_idx_o;

  typedef struct {
    logic [31:0] ftw;
    logic [15:0] idx;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  dds_hop_sched dut (
    .clk_user_bufg (clk_user_bufg),
    .rst_glb       (rst_glb),
    .run_en        (run_en),
    .cfg_mode      (cfg_mode),
    .cfg_fix_khz   (cfg_fix_khz),
    .cfg_start_khz (cfg_start_khz),
    .cfg_stop_khz  (cfg_stop_khz),
    .cfg_step_khz  (cfg_step_khz),
    .cfg_dwell     (cfg_dwell),
    .cfg_prt_cycle (cfg_prt_cycle),
    .cfg_prt_width (cfg_prt_width),
    .ftw_o         (ftw_o),
    .ftw_upd_o     (ftw_upd_o),
    .prt_o         (prt_o),
    .hop_idx_o     (hop_idx_o),
    .busy_o        (busy_o),
    .cfg_err_o     (cfg_err_o)
  );

  always #5 clk_user_bufg = ~clk_user_bufg;
  always @(posedge clk_user_bufg) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] khz2ftw(input logic [31:0] khz);
    return khz * 32'd4295;
  endfunction

  task automatic push_exp(input int khz, input int idx, input int c);
    exp_t e;
    e.ftw = khz2ftw(khz);
    e.idx = 16'(idx);
    e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic set_cfg(input logic [1:0] mode, input logic [23:0] fix, input logic [23:0] start,
                         input logic [23:0] stop, input logic [15:0] step, input logic [31:0] dwell);
    cfg_mode      = mode;
    cfg_fix_khz   = fix;
    cfg_start_khz = start;
    cfg_stop_khz  = stop;
    cfg_step_khz  = step;
    cfg_dwell     = dwell;
  endtask

  // t0 is the cycle on which the first strobe must be observed.
  task automatic start_run(output int t0);
    @(negedge clk_user_bufg);
    run_en = 1'b0;
    @(negedge clk_user_bufg);
    run_en = 1'b1;
    t0 = cyc + 3;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk_user_bufg);
  endtask

  task automatic stop_run();
    run_en = 1'b0;
    @(negedge clk_user_bufg);
  endtask

  task automatic test_reset();
    rst_glb = 1'b0;
    run_en  = 1'b0;
    set_cfg(2'd1, 24'd5, 24'd1000, 24'd2000, 16'd10, 32'd3);
    cfg_prt_cycle = 32'd10;
    cfg_prt_width = 32'd3;
    repeat (3) @(negedge clk_user_bufg);
    vectors++; if (ftw_o !== 32'd0) begin miscompares++; $display("FAIL reset_ftw: got %0d want 0", ftw_o); end
    vectors++; if (ftw_upd_o !== 1'b0) begin miscompares++; $display("FAIL reset_upd: got %b want 0", ftw_upd_o); end
    vectors++; if (hop_idx_o !== 16'd0) begin miscompares++; $display("FAIL reset_idx: got %0d want 0", hop_idx_o); end
    vectors++; if ({busy_o, cfg_err_o, prt_o} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {busy_o, cfg_err_o, prt_o}); end
    rst_glb = 1'b1;
    repeat (3) @(negedge clk_user_bufg);
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_fixed();
    int t0;
    set_cfg(2'd0, 24'd10000, 24'd1, 24'd2, 16'd1, 32'd5);
    start_run(t0);
    push_exp(10000, 0, t0);
    @(negedge clk_user_bufg);
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL fixed_busy_load: got %b want 1", busy_o); end
    wait_cyc(t0 + 20);
    vectors++; if (sb_q.size() !== 0) begin miscompares++; $display("FAIL fixed_strobe_missing: got %0d pending want 0", sb_q.size()); end
    stop_run();
    vectors++; if (ftw_o !== 32'd42950000) begin miscompares++; $display("FAIL fixed_ftw_held: got %0d want 42950000", ftw_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL fixed_busy_idle: got %b want 0", busy_o); end
  endtask

  task automatic test_wrap();
    int t0;
    int kz[5] = '{1000, 1100, 1200, 1300, 1000};
    int ix[5] = '{0, 1, 2, 3, 0};
    set_cfg(2'd1, 24'd0, 24'd1000, 24'd1300, 16'd100, 32'd4);
    start_run(t0);
    for (int i = 0; i < 5; i++) push_exp(kz[i], ix[i], t0 + 4 * i);
    wait_cyc(t0 + 16);
    stop_run();
    vectors++; if (sb_q.size() !== 0) begin miscompares++; $display("FAIL wrap_pending: got %0d want 0", sb_q.size()); sb_q.delete(); end
  endtask

  task automatic test_bounce();
    int t0;
    int kz[8] = '{1000, 1100, 1200, 1300, 1200, 1100, 1000, 1100};
    set_cfg(2'd2, 24'd0, 24'd1000, 24'd1300, 16'd100, 32'd4);
    start_run(t0);
    for (int i = 0; i < 8; i++) push_exp(kz[i], i, t0 + 4 * i);
    wait_cyc(t0 + 28);
    stop_run();
    vectors++; if (sb_q.size() !== 0) begin miscompares++; $display("FAIL bounce_pending: got %0d want 0", sb_q.size()); sb_q.delete(); end
  endtask

  task automatic test_bounce_clamp();
    int t0;
    int kz[5] = '{1000, 1000, 1050, 1000, 1050};
    set_cfg(2'd2, 24'd0, 24'd1000, 24'd1050, 16'd100, 32'd2);
    start_run(t0);
    for (int i = 0; i < 5; i++) push_exp(kz[i], i, t0 + 2 * i);
    wait_cyc(t0 + 8);
    stop_run();
    vectors++; if (sb_q.size() !== 0) begin miscompares++; $display("FAIL clamp_pending: got %0d want 0", sb_q.size()); sb_q.delete(); end
  endtask

  task automatic test_start_eq_stop();
    int t0;
    set_cfg(2'd2, 24'd0, 24'd500, 24'd500, 16'd50, 32'd0);
    start_run(t0);
    for (int i = 0; i < 5; i++) push_exp(500, i, t0 + i);
    wait_cyc(t0 + 4);
    stop_run();
    vectors++; if (sb_q.size() !== 0) begin miscompares++; $display("FAIL eq_bounce_pending: got %0d want 0", sb_q.size()); sb_q.delete(); end
    set_cfg(2'd1, 24'd0, 24'd700, 24'd700, 16'd5, 32'd3);
    start_run(t0);
    for (int i = 0; i < 3; i++) push_exp(700, 0, t0 + 3 * i);
    wait_cyc(t0 + 6);
    stop_run();
    vectors++; if (sb_q.size() !== 0) begin miscompares++; $display("FAIL eq_wrap_pending: got %0d want 0", sb_q.size()); sb_q.delete(); end
  endtask

  task automatic test_top_range();
    int t0;
    set_cfg(2'd1, 24'd0, 24'd16777000, 24'd16777215, 16'd65535, 32'd2);
    start_run(t0);
    for (int i = 0; i < 3; i++) push_exp(16777000, 0, t0 + 2 * i);
    wait_cyc(t0 + 4);
    stop_run();
    vectors++; if (sb_q.size() !== 0) begin miscompares++; $display("FAIL top_range_pending: got %0d want 0", sb_q.size()); sb_q.delete(); end
  endtask

  task automatic test_err();
    int t0;
    set_cfg(2'd1, 24'd0, 24'd2000, 24'd1000, 16'd100, 32'd4);
    start_run(t0);
    wait_cyc(t0 + 5);
    vectors++; if (cfg_err_o !== 1'b1) begin miscompares++; $display("FAIL err_flag: got %b want 1", cfg_err_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL err_busy: got %b want 0", busy_o); end
    stop_run();
    vectors++; if (cfg_err_o !== 1'b0) begin miscompares++; $display("FAIL err_clear: got %b want 0", cfg_err_o); end
    set_cfg(2'd2, 24'd0, 24'd1000, 24'd2000, 16'd0, 32'd4);
    start_run(t0);
    wait_cyc(t0 + 3);
    vectors++; if (cfg_err_o !== 1'b1) begin miscompares++; $display("FAIL err_step0: got %b want 1", cfg_err_o); end
    stop_run();
  endtask

  task automatic test_prt();
    int   t0;
    logic exp_prt;
    set_cfg(2'd0, 24'd5000, 24'd0, 24'd0, 16'd0, 32'd7);
    cfg_prt_cycle = 32'd10;
    cfg_prt_width = 32'd3;
    start_run(t0);
    push_exp(5000, 0, t0);
    wait_cyc(t0 - 1);
    for (int k = 0; k < 30; k++) begin
`ifdef DDS_HOP_PRT_EN
      exp_prt = ((k % 10) < 3);
`else
      exp_prt = 1'b0;
`endif
      vectors++; if (prt_o !== exp_prt) begin miscompares++; $display("FAIL prt_pattern k=%0d: got %b want %b", k, prt_o, exp_prt); end
      @(negedge clk_user_bufg);
    end
    stop_run();
    vectors++; if (prt_o !== 1'b0) begin miscompares++; $display("FAIL prt_idle: got %b want 0", prt_o); end
    cfg_prt_cycle = 32'd0;
    start_run(t0);
    push_exp(5000, 0, t0);
    wait_cyc(t0 - 1);
    for (int k = 0; k < 12; k++) begin
      vectors++; if (prt_o !== 1'b0) begin miscompares++; $display("FAIL prt_cycle0 k=%0d: got %b want 0", k, prt_o); end
      @(negedge clk_user_bufg);
    end
    stop_run();
    cfg_prt_cycle = 32'd10;
    cfg_prt_width = 32'd12;
    start_run(t0);
    push_exp(5000, 0, t0);
    wait_cyc(t0 + 4);
`ifdef DDS_HOP_PRT_EN
    exp_prt = 1'b1;
`else
    exp_prt = 1'b0;
`endif
    vectors++; if (prt_o !== exp_prt) begin miscompares++; $display("FAIL prt_wide: got %b want %b", prt_o, exp_prt); end
    stop_run();
    vectors++; if (sb_q.size() !== 0) begin miscompares++; $display("FAIL prt_pending: got %0d want 0", sb_q.size()); sb_q.delete(); end
  endtask

  task automatic test_run_held_reset();
    int t0;
    set_cfg(2'd1, 24'd0, 24'd3000, 24'd3300, 16'd100, 32'd3);
    @(negedge clk_user_bufg);
    rst_glb = 1'b0;
    run_en  = 1'b1;
    repeat (3) @(negedge clk_user_bufg);
    rst_glb = 1'b1;
    repeat (10) @(negedge clk_user_bufg);
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL held_busy: got %b want 0", busy_o); end
    start_run(t0);
    push_exp(3000, 0, t0);
    push_exp(3100, 1, t0 + 3);
    wait_cyc(t0 + 3);
    stop_run();
    vectors++; if (sb_q.size() !== 0) begin miscompares++; $display("FAIL held_pending: got %0d want 0", sb_q.size()); sb_q.delete(); end
  endtask

  task automatic test_reset_mid();
    int t0;
    set_cfg(2'd1, 24'd0, 24'd1000, 24'd1300, 16'd100, 32'd4);
    start_run(t0);
    push_exp(1000, 0, t0);
    push_exp(1100, 1, t0 + 4);
    wait_cyc(t0 + 6);
    rst_glb = 1'b0;
    #1;
    vectors++; if (ftw_o !== 32'd0) begin miscompares++; $display("FAIL mid_rst_ftw: got %0d want 0", ftw_o); end
    vectors++; if (hop_idx_o !== 16'd0) begin miscompares++; $display("FAIL mid_rst_idx: got %0d want 0", hop_idx_o); end
    vectors++; if ({ftw_upd_o, busy_o, cfg_err_o, prt_o} !== 4'b0000) begin miscompares++; $display("FAIL mid_rst_flags: got %b want 0000", {ftw_upd_o, busy_o, cfg_err_o, prt_o}); end
    vectors++; if (sb_q.size() !== 0) begin miscompares++; $display("FAIL mid_rst_pending: got %0d want 0", sb_q.size()); sb_q.delete(); end
    @(negedge clk_user_bufg);
    rst_glb = 1'b1;
    repeat (5) @(negedge clk_user_bufg);
    start_run(t0);
    push_exp(1000, 0, t0);
    wait_cyc(t0);
    stop_run();
    vectors++; if (sb_q.size() !== 0) begin miscompares++; $display("FAIL mid_restart_pending: got %0d want 0", sb_q.size()); sb_q.delete(); end
  endtask

  initial begin
    exp_t e;
    fork
      forever begin
        @(negedge clk_user_bufg);
        if (ftw_upd_o === 1'b1) begin
          vectors++;
          if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_strobe: got ftw=%0d idx=%0d at cycle %0d, want no strobe", ftw_o, hop_idx_o, cyc);
          end else begin
            e = sb_q.pop_front();
            if (ftw_o !== e.ftw || hop_idx_o !== e.idx || cyc !== e.cyc) begin
              miscompares++;
              $display("FAIL strobe: got ftw=%0d idx=%0d cyc=%0d want ftw=%0d idx=%0d cyc=%0d",
                       ftw_o, hop_idx_o, cyc, e.ftw, e.idx, e.cyc);
            end
          end
        end
      end
    join_none

    test_reset();
    test_fixed();
    test_wrap();
    test_bounce();
    test_bounce_clamp();
    test_start_eq_stop();
    test_top_range();
    test_err();
    test_prt();
    test_run_held_reset();
    test_reset_mid();
    repeat (5) @(negedge clk_user_bufg);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
